// File: rtl/spi_reg_master.sv
// SPI initiator for single-register read/write frames (rw, addr[6:0], data[7:0]), all CPOL/CPHA modes.
// Every SPI output is registered; spi_clk only follows the live cpol input while idle.
//
// state   | meaning
// IDLE    | cs_n high, waiting for start
// SETUP   | cs_n low, first bit presented, one half-period before edge 1
// XFER    | 32 SCLK edges, one per half-period
// HOLD    | SCLK idle, cs_n still low for one half-period
// GAP     | cs_n high for one half-period, done in the last cycle
module spi_reg_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       spi_cs_n,
   output logic       spi_clk,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] DIV_PRE  = 8'(CLK_DIV - 2);

   generate
      if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_div
         $error("spi_reg_master: CLK_DIV must be in 4..255");
      end
   endgenerate

   logic [2:0]  state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [5:0]  edge_q, edge_d;
   logic [15:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        cpha_q, cpha_d;
   logic        rw_q, rw_d;
   logic        clk_q, clk_d;
   logic        cs_n_q, cs_n_d;
   logic        mosi_q, mosi_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        tick;
   logic [5:0]  nxt_edge;

   always_comb begin
      state_d  = state_q;
      edge_d   = edge_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      cpha_d   = cpha_q;
      rw_d     = rw_q;
      clk_d    = clk_q;
      cs_n_d   = cs_n_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      tick     = (div_q == DIV_LAST);
      nxt_edge = edge_q + 6'd1;
      div_d    = (state_q == S_IDLE || tick) ? 8'd0 : div_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETUP;
               cpha_d  = cpha;
               rw_d    = rw;
               tx_d    = {rw, addr, (rw ? wdata : 8'h00)};
               rx_d    = 16'h0000;
               edge_d  = 6'd0;
               cs_n_d  = 1'b0;
               clk_d   = cpol;
               mosi_d  = cpha ? 1'b0 : rw;
               busy_d  = 1'b1;
            end
         end
         S_SETUP, S_XFER: begin
            if (tick && edge_q != 6'd32) begin
               state_d = (nxt_edge == 6'd32) ? S_HOLD : S_XFER;
               edge_d  = nxt_edge;
               clk_d   = ~clk_q;
               // sample on odd edges in cpha=0, even edges in cpha=1
               if (nxt_edge[0] ^ cpha_q) begin
                  rx_d = {rx_q[14:0], spi_miso};
               end else if (cpha_q) begin
                  mosi_d = tx_q[15];
                  tx_d   = {tx_q[14:0], 1'b0};
               end else if (nxt_edge <= 6'd30) begin
                  mosi_d = tx_q[14];
                  tx_d   = {tx_q[14:0], 1'b0};
               end
            end
         end
         S_HOLD: begin
            if (tick) begin
               state_d = S_GAP;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
            end
         end
         S_GAP: begin
            if (div_q == DIV_PRE) begin
               done_d = 1'b1;
               if (!rw_q) begin
                  rdata_d = rx_q[7:0];
               end
            end
            if (tick) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         edge_q  <= 6'd0;
         tx_q    <= 16'h0000;
         rx_q    <= 16'h0000;
         rdata_q <= 8'h00;
         cpha_q  <= 1'b0;
         rw_q    <= 1'b0;
         clk_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         cpha_q  <= cpha_d;
         rw_q    <= rw_d;
         clk_q   <= clk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign spi_clk  = (state_q == S_IDLE) ? cpol : clk_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = mosi_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: frame vectors against an SPI responder model, plus back-to-back,
// mid-frame reset and CLK_DIV=7 sequences.
module tb_spi_reg_master;

   typedef struct {
      logic        cpol;
      logic        cpha;
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  resp;
      logic [15:0] exp_frame;
      logic [7:0]  exp_rdata;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpol = 1'b0, cpha = 1'b0, rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [7:0] wdata = 8'h00;
   logic       start4 = 1'b0, start7 = 1'b0;
   logic       spi_miso = 1'b0;

   logic [7:0] rdata4, rdata7;
   logic       busy4, done4, cs4, sclk4, mosi4;
   logic       busy7, done7, cs7, sclk7, mosi7;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   spi_reg_master #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .start(start4), .rw(rw),
      .addr(addr), .wdata(wdata), .rdata(rdata4), .busy(busy4), .done(done4),
      .spi_cs_n(cs4), .spi_clk(sclk4), .spi_mosi(mosi4), .spi_miso(spi_miso));

   spi_reg_master #(.CLK_DIV(7)) u_dut7 (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .start(start7), .rw(rw),
      .addr(addr), .wdata(wdata), .rdata(rdata7), .busy(busy7), .done(done7),
      .spi_cs_n(cs7), .spi_clk(sclk7), .spi_mosi(mosi7), .spi_miso(spi_miso));

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   logic       sel7 = 1'b0;
   logic       mon_cs, mon_clk, mon_mosi, mon_busy, mon_done;
   logic [7:0] mon_rdata;
   assign mon_cs    = sel7 ? cs7    : cs4;
   assign mon_clk   = sel7 ? sclk7  : sclk4;
   assign mon_mosi  = sel7 ? mosi7  : mosi4;
   assign mon_busy  = sel7 ? busy7  : busy4;
   assign mon_done  = sel7 ? done7  : done4;
   assign mon_rdata = sel7 ? rdata7 : rdata4;

   // Responder model: captures the 16-bit MOSI frame, returns {8'h00, resp} on MISO
   logic        m_cpol = 1'b0, m_cpha = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic [15:0] m_tx = 16'h0000, m_cap = 16'h0000;
   int          m_idx = 0;
   logic        m_prev_cs = 1'b1, m_prev_clk = 1'b0, m_lead;
   logic [15:0] frame_log [0:31];
   int          nfr = 0;

   always @(mon_cs or mon_clk) begin
      if (m_prev_cs === 1'b1 && mon_cs === 1'b0) begin
         m_cap = 16'h0000;
         m_tx  = {8'h00, resp};
         if (!m_cpha) begin
            spi_miso = m_tx[15];
            m_idx    = 14;
         end else begin
            m_idx = 15;
         end
      end else if (m_prev_cs === 1'b0 && mon_cs === 1'b1) begin
         if (nfr < 32) frame_log[nfr] = m_cap;
         nfr = nfr + 1;
         spi_miso = 1'b0;
      end else if (mon_cs === 1'b0 && mon_clk !== m_prev_clk) begin
         m_lead = (mon_clk != m_cpol);
         if (m_lead != m_cpha) begin
            m_cap = {m_cap[14:0], mon_mosi};
         end else if (m_idx >= 0) begin
            spi_miso = m_tx[m_idx];
            m_idx    = m_idx - 1;
         end
      end
      m_prev_cs  = mon_cs;
      m_prev_clk = mon_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_inputs(input vec_t v);
      cpol = v.cpol; cpha = v.cpha; rw = v.rw; addr = v.addr; wdata = v.wdata;
   endtask

   task automatic run_frame(input string tag, input vec_t v, input bit use7);
      int d, t0, t_csf, t_busyr, t_csr, t_done, t_bf, nedge, ndone, first_e, last_e, bad_sp, nfr0;
      logic prev_clk, prev_cs, prev_busy, clk_at_csf, clk_at_csr, mosi_at_csr;
      logic [7:0] rd_at_done;
      d = use7 ? 7 : 4;
      t_csf = -1; t_busyr = -1; t_csr = -1; t_done = -1; t_bf = -1;
      nedge = 0; ndone = 0; first_e = -1; last_e = -1; bad_sp = 0;
      clk_at_csf = 1'bx; clk_at_csr = 1'bx; mosi_at_csr = 1'bx; rd_at_done = 8'hxx;
      sel7 = use7; m_cpol = v.cpol; m_cpha = v.cpha; resp = v.resp;
      apply_inputs(v);
      @(negedge clk);
      nfr0 = nfr;
      prev_clk = mon_clk; prev_cs = mon_cs; prev_busy = mon_busy;
      t0 = cyc;
      if (use7) start7 = 1'b1; else start4 = 1'b1;
      for (int i = 0; i < 40 * d + 20; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start4 = 1'b0; start7 = 1'b0;
            cpol = ~v.cpol; cpha = ~v.cpha; rw = ~v.rw; addr = ~v.addr; wdata = ~v.wdata;
         end
         if (prev_cs && !mon_cs) begin t_csf = cyc; clk_at_csf = mon_clk; end
         if (!prev_cs && mon_cs) begin t_csr = cyc; clk_at_csr = mon_clk; mosi_at_csr = mon_mosi; end
         if (!prev_busy && mon_busy) t_busyr = cyc;
         if (prev_busy && !mon_busy) t_bf = cyc;
         if (mon_clk !== prev_clk) begin
            nedge = nedge + 1;
            if (nedge == 1) first_e = cyc;
            else if (cyc - last_e != d) bad_sp = bad_sp + 1;
            last_e = cyc;
         end
         if (mon_done) begin
            ndone = ndone + 1;
            t_done = cyc;
            rd_at_done = mon_rdata;
            apply_inputs(v);
         end
         prev_clk = mon_clk; prev_cs = mon_cs; prev_busy = mon_busy;
         if (t_bf >= 0) break;
      end
      chk({tag, "_finished"}, (t_bf >= 0), 1);
      chk({tag, "_csfall"}, t_csf, t0 + 1);
      chk({tag, "_busyrise"}, t_busyr, t0 + 1);
      chk({tag, "_sclk_idle_before"}, clk_at_csf, v.cpol);
      chk({tag, "_nedges"}, nedge, 32);
      chk({tag, "_edge1"}, first_e, t0 + 1 + d);
      chk({tag, "_edge32"}, last_e, t0 + 1 + 32 * d);
      chk({tag, "_edge_spacing_errs"}, bad_sp, 0);
      chk({tag, "_csrise"}, t_csr, t0 + 1 + 33 * d);
      chk({tag, "_sclk_idle_after"}, clk_at_csr, v.cpol);
      chk({tag, "_mosi_gap"}, mosi_at_csr, 0);
      chk({tag, "_done_time"}, t_done, t0 + 34 * d);
      chk({tag, "_done_count"}, ndone, 1);
      chk({tag, "_busyfall"}, t_bf, t0 + 1 + 34 * d);
      chk({tag, "_nframes"}, nfr - nfr0, 1);
      chk({tag, "_frame"}, frame_log[nfr0], v.exp_frame);
      chk({tag, "_rdata_done"}, rd_at_done, v.exp_rdata);
      chk({tag, "_rdata_after"}, mon_rdata, v.exp_rdata);
   endtask

   vec_t vecs [8];
   vec_t vr;
   int   t_d, t_f, nd, nb, nedge, nfr0;
   logic prev, hit;

   initial begin
      //           cpol  cpha  rw    addr   wdata  resp   frame     rdata
      vecs[0] = '{1'b0, 1'b0, 1'b1, 7'h02, 8'h35, 8'h00, 16'h8235, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 7'h08, 8'h00, 8'hA7, 16'h0800, 8'hA7};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 7'h1F, 8'h5A, 8'h3C, 16'h9F5A, 8'hA7};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 7'h1F, 8'h5A, 8'h3C, 16'h9F5A, 8'hA7};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 7'h1F, 8'h5A, 8'h3C, 16'h9F5A, 8'hA7};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 7'h1F, 8'h5A, 8'h3C, 16'h9F5A, 8'hA7};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 7'h7F, 8'hEE, 8'h5C, 16'h7F00, 8'h5C};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 7'h00, 8'h11, 8'hC3, 16'h0000, 8'hC3};

      // reset state, with cpol high so spi_clk must follow it
      cpol = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_cs_n", cs4, 1);
      chk("rst_sclk", sclk4, 1);
      chk("rst_mosi", mosi4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_rdata", rdata4, 8'h00);
      rst = 1'b0;
      cpol = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_frame($sformatf("v%0d", i), vecs[i], 1'b0);
      end

      // start held high: back-to-back frames, mid-frame rw/addr change ignored
      sel7 = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; resp = 8'h4B;
      cpol = 1'b0; cpha = 1'b0; rw = 1'b1; addr = 7'h11; wdata = 8'h22;
      @(negedge clk);
      nfr0 = nfr;
      start4 = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!cs4) begin hit = 1'b1; break; end
      end
      chk("b2b_first_csfall", hit, 1);
      rw = 1'b0; addr = 7'h33; wdata = 8'hFF;
      t_d = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done4) begin t_d = cyc; break; end
      end
      chk("b2b_first_done", (t_d >= 0), 1);
      t_f = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!cs4) begin t_f = cyc; break; end
      end
      chk("b2b_restart_gap", t_f, t_d + 2);
      start4 = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy4) begin hit = 1'b1; break; end
      end
      chk("b2b_second_finished", hit, 1);
      chk("b2b_frame1", frame_log[nfr0], 16'h9122);
      chk("b2b_frame2", frame_log[nfr0 + 1], 16'h3300);
      chk("b2b_rdata", rdata4, 8'h4B);

      // reset at edge 17 of a read
      sel7 = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; resp = 8'h99;
      cpol = 1'b0; cpha = 1'b0; rw = 1'b0; addr = 7'h05; wdata = 8'h00;
      @(negedge clk);
      start4 = 1'b1;
      prev = sclk4; nedge = 0; hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (sclk4 !== prev) nedge = nedge + 1;
         prev = sclk4;
         if (nedge == 17) begin hit = 1'b1; break; end
      end
      chk("rstmid_reach_edge17", hit, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_cs_n", cs4, 1);
      chk("rstmid_busy", busy4, 0);
      chk("rstmid_rdata", rdata4, 8'h00);
      chk("rstmid_done", done4, 0);
      chk("rstmid_mosi", mosi4, 0);
      chk("rstmid_sclk", sclk4, 0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0; nb = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done4) nd = nd + 1;
         if (busy4) nb = nb + 1;
      end
      chk("rstmid_no_done", nd, 0);
      chk("rstmid_no_busy", nb, 0);
      vr = '{1'b0, 1'b0, 1'b0, 7'h05, 8'h00, 8'h99, 16'h0500, 8'h99};
      run_frame("post_rst", vr, 1'b0);

      // CLK_DIV = 7 write
      vr = '{1'b0, 1'b0, 1'b1, 7'h2A, 8'hC6, 8'h00, 16'hAAC6, 8'h00};
      run_frame("div7", vr, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
